// File: rtl/eu_issue_buffer_pkg.sv
// eu_issue_buffer_pkg: shared bus layouts, widths and helpers for the EU issue buffer
//   port_s2e_t    : instruction to EU {pc, futype, valid}
//   port_e2s_t    : EU status {fumask, ready}
//   fubr_result_t : branch resolution {spectag, mispred, valid}
package eu_issue_buffer_pkg;
    localparam int SPEC_STATES = 8;
    localparam int FU_TYPES = 8;
    localparam int ISSBUF_DEPTH_DEFAULT = 4;
    typedef enum logic [2:0] {FU_ALU, FU_MUL, FU_IDIV, FU_FPU, FU_FDIV, FU_LDST, FU_BR, FU_MISC} fu_type_e;
    typedef logic [SPEC_STATES-1:0] spec_mask_t;
    typedef struct packed {
        logic [31:0] pc;
        fu_type_e    futype;
        logic        valid;
    } port_s2e_t;
    typedef struct packed {
        logic [FU_TYPES-1:0] fumask;
        logic                ready;
    } port_e2s_t;
    typedef struct packed {
        spec_mask_t spectag;
        logic       mispred;
        logic       valid;
    } fubr_result_t;
    localparam int PORT_S2E_LEN = $bits(port_s2e_t);
    localparam int PORT_E2S_LEN = $bits(port_e2s_t);
    localparam int FUBR_RESULT_LEN = $bits(fubr_result_t);
    function automatic port_s2e_t mk_s2e(logic [31:0] pc, fu_type_e futype);
        return '{pc: pc, futype: futype, valid: 1'b0};
    endfunction
endpackage

// File: rtl/eu_issue_buffer_if.sv
// eu_issue_buffer_if: select-side issue handshake and EU-side transfer bus
//   master: drives Iss_Valid/Iss_Data/Iss_SpecMask/Port_E2S, sees Iss_Ready/Port_S2E
//   slave : the issue buffer
interface eu_issue_buffer_if;
    import eu_issue_buffer_pkg::*;
    logic       Iss_Valid;
    port_s2e_t  Iss_Data;
    spec_mask_t Iss_SpecMask;
    logic       Iss_Ready;
    port_e2s_t  Port_E2S;
    port_s2e_t  Port_S2E;
    modport master (output Iss_Valid, Iss_Data, Iss_SpecMask, Port_E2S, input Iss_Ready, Port_S2E);
    modport slave (input Iss_Valid, Iss_Data, Iss_SpecMask, Port_E2S, output Iss_Ready, Port_S2E);
endinterface

// File: rtl/eu_issue_buffer_spec_kill_check.sv
// eu_issue_buffer_spec_kill_check: per-mask mispredict kill and resolved-tag clearing
//   mask, fubr in; kill, cleared_mask out (combinational)
module eu_issue_buffer_spec_kill_check
    import eu_issue_buffer_pkg::*;
(
    input  spec_mask_t   mask,
    input  fubr_result_t fubr,
    output logic         kill,
    output spec_mask_t   cleared_mask
);
    assign kill = fubr.valid & fubr.mispred & |(mask & fubr.spectag);
    assign cleared_mask = (fubr.valid & ~fubr.mispred) ? mask & ~fubr.spectag : mask;
endmodule

// File: rtl/eu_issue_buffer.sv
// eu_issue_buffer: in-order issue buffer between select logic and an execution unit
//   clk, rst (sync, active high), Flush, FUBRresp : control and branch resolution
//   bus (slave)  : issue handshake in, Port_S2E out, Port_E2S status in
//   Occupancy    : allocated slots including killed holes
//   FUTypeErr    : registered pulse when a transferred FU type is not in FUMASK
module eu_issue_buffer
    import eu_issue_buffer_pkg::*;
#(
    parameter int DEPTH = ISSBUF_DEPTH_DEFAULT,
    localparam int AW = $clog2(DEPTH),
    localparam int PW = AW + 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              Flush,
    input  fubr_result_t      FUBRresp,
    eu_issue_buffer_if.slave  bus,
    output logic [PW-1:0]     Occupancy,
    output logic              FUTypeErr
);
    logic [DEPTH-1:0] vld_q;
    spec_mask_t       mask_q [DEPTH];
    port_s2e_t        data_q [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [DEPTH-1:0] kill_s;
    spec_mask_t       mask_clr [DEPTH];
    logic             kill_in;
    spec_mask_t       mask_in;
    logic [AW-1:0]    rd_idx, wr_idx;
    logic             hv, xfer, pop, enq;
    port_s2e_t        head;
    genvar i;
    for (i = 0; i < DEPTH; i++) begin : g_slot
        eu_issue_buffer_spec_kill_check u_chk (
            .mask(mask_q[i]), .fubr(FUBRresp), .kill(kill_s[i]), .cleared_mask(mask_clr[i])
        );
    end
    eu_issue_buffer_spec_kill_check u_chk_in (
        .mask(bus.Iss_SpecMask), .fubr(FUBRresp), .kill(kill_in), .cleared_mask(mask_in)
    );
    always_comb begin
        rd_idx = rd_ptr[AW-1:0];
        wr_idx = wr_ptr[AW-1:0];
        Occupancy = wr_ptr - rd_ptr;
        head = data_q[rd_idx];
        hv = vld_q[rd_idx] & ~kill_s[rd_idx] & (Occupancy != '0);
        xfer = hv & bus.Port_E2S.ready & ~Flush & ~rst;
        // holes and heads killed this cycle pop without waiting for the EU
        pop = (Occupancy != '0) & (~hv | bus.Port_E2S.ready);
        bus.Iss_Ready = ~Flush & ~rst & (Occupancy < PW'(DEPTH));
        enq = bus.Iss_Valid & bus.Iss_Ready;
        bus.Port_S2E = xfer ? port_s2e_t'(head | PORT_S2E_LEN'(1)) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst || Flush) begin
            vld_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            FUTypeErr <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k] & ~kill_s[k];
                mask_q[k] <= mask_clr[k];
            end
            if (enq) begin
                vld_q[wr_idx] <= ~kill_in;
                mask_q[wr_idx] <= mask_in;
                data_q[wr_idx] <= bus.Iss_Data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            FUTypeErr <= xfer & ~bus.Port_E2S.fumask[head.futype];
        end
    end
endmodule

// File: doc/eu_issue_buffer.md
Name: eu_issue_buffer

Overview:
- Small in-order issue buffer between one scheduler port's select logic and its execution unit (EU).
- Accepts issued instructions already packed in Port_S2E format and holds them until the EU signals ready.
- Kills held instructions on branch mispredict via speculative-tag masks, and clears resolved tags on correct prediction.
- Lets select issue back-to-back while the EU stalls on multi-cycle FUs (IDIV, FDIV, load/store).

Parameters:
- DEPTH, 4, number of buffer slots; power of two, minimum 2.
- PORTID, -1, port index used only in debug prints.

Ports:
- clk  in  1  core clock. One clock domain; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Flush  in  1  pipeline flush; drops all held and incoming instructions.
- FUBRresp  in  `FUBR_RESULT_LEN  branch resolution bus (VALID, MISPRED, SPECTAG fields).
- Iss_Valid  in  1  select logic presents an instruction.
- Iss_Data  in  `PORT_S2E_LEN  packed instruction; its PORT_S2E_VALID bit is ignored.
- Iss_SpecMask  in  `SPEC_STATES  speculative-tag dependency mask of the instruction.
- Iss_Ready  out  1  buffer can accept an instruction this cycle.
- Port_E2S  in  `PORT_E2S_LEN  EU status (PORT_E2S_READY, PORT_E2S_FUMASK).
- Port_S2E  out  `PORT_S2E_LEN  instruction to EU; PORT_S2E_VALID marks a transfer.
- Occupancy  out  $clog2(DEPTH)+1  allocated slot count, including killed holes.
- FUTypeErr  out  1  pulse: a head instruction's FU type is absent from PORT_E2S_FUMASK.

Behaviour:
- Storage: circular buffer of DEPTH slots. Each slot holds vld, data, specmask. Pointers wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide, with a wrap bit.
- Reset: all slot vld = 0, pointers = 0.
  - Outputs after reset: Iss_Ready = 1, Port_S2E = 0, Occupancy = 0, FUTypeErr = 0.
- Kill condition for mask m: kill(m) = FUBRresp[VALID] & FUBRresp[MISPRED] & |(m & FUBRresp[SPECTAG]).
- Resolve condition: resolve = FUBRresp[VALID] & ~FUBRresp[MISPRED]. On resolve, every stored specmask clears the FUBRresp[SPECTAG] bits. The incoming Iss_SpecMask is cleared the same way before it is written.
- Enqueue:
  - Iss_Ready = (Occupancy < DEPTH).
  - Enqueue occurs when Iss_Valid & Iss_Ready & ~Flush. It writes slot[wr_ptr] and increments wr_ptr.
  - The slot's vld = ~kill(Iss_SpecMask). A killed incoming instruction still consumes the slot as a hole.
  - Iss_Valid while Iss_Ready = 0 is a protocol error. Data is dropped and a DEBUG $display is issued.
- Head output is combinational from registered state:
  - hv = slot[rd_ptr].vld & ~kill(slot[rd_ptr].specmask) & (Occupancy != 0).
  - Port_S2E = data with VALID bit set when hv & Port_E2S[READY]; otherwise Port_S2E = 0.
- Dequeue: at most one per cycle; rd_ptr increments when either:
  - a head transfer occurs; or
  - the head slot is allocated but invalid or killed this cycle (bubble pop, no EU transfer).
- Latency: an instruction enqueued in cycle N can reach the EU in cycle N+1 at the earliest. No same-cycle bypass.
- Kill of non-head slots: vld is cleared at the clock edge. The slot stays allocated until it reaches head, then pops as a bubble.
- Simultaneous enqueue and dequeue with the buffer full: dequeue frees a slot only at the edge. Iss_Ready stays 0 that cycle (no full-cycle bypass).
- Flush (priority over everything):
  - At the edge, all vld = 0 and wr_ptr = rd_ptr = 0.
  - In the Flush cycle: Port_S2E = 0, the incoming instruction is dropped, Iss_Ready = 0.
- Reset asserted mid-operation behaves like Flush plus clears FUTypeErr.
- FUTypeErr is registered, set for one cycle when:
  - hv & Port_E2S[READY] & ~Port_E2S[FUMASK][data.FUTYPE].
  - The transfer still occurs.
- Full/empty: full = pointer indices equal with wrap bits differing; empty = pointers equal.

Decomposition:
- Shared core_defines/bus_defines: PORT_S2E_*, PORT_E2S_*, FUBR_RESULT_* field macros and SPEC_STATES. Add ISSBUF_DEPTH_DEFAULT there.
- Natural sub-module: spec_kill_check. Combinational; inputs mask and FUBRresp; outputs kill and cleared_mask. Instantiate it DEPTH+1 times (slots plus incoming).

Test Plan:
- Enqueue 3 instructions (PC 0x100, 0x104, 0x108) with EU READY held 0 for 5 cycles, then 1 → Occupancy reaches 3; Port_S2E issues the PCs in order on three consecutive cycles; Occupancy returns to 0.
- DEPTH=4: fill with READY=0 → Iss_Ready = 0 at Occupancy 4. Next, same cycle one dequeue and Iss_Valid → no enqueue that cycle; enqueue accepted the following cycle.
- Slots hold specmasks 0x01, 0x02, 0x00; FUBRresp VALID=1, MISPRED=1, SPECTAG=0x02 → slot 2 killed. Issued sequence is slot 1, one bubble cycle, slot 3. Port_S2E VALID is never asserted for slot 2.
- Head specmask 0x04 with READY=1 and a same-cycle mispredict on tag 0x04 → Port_S2E = 0 that cycle; the next cycle issues the following slot.
- Correct resolve (MISPRED=0, SPECTAG=0x01) on a slot with mask 0x03, then mispredict on 0x01 → the slot survives and issues.
- Flush with 3 held plus an incoming instruction → the next cycle Occupancy = 0, Iss_Ready = 1, Port_S2E = 0. Repeat using rst instead and check identical state.
